// File: rtl/frog_pkg.sv
// frog_pkg: shared types and default geometry for the Frogger player-control stage.
// Holds the game-state and move-direction enums, the default grid geometry,
// the start-cell constants and the cell-index to pixel conversion helper.
package frog_pkg;

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        WIN_HOLD  = 2'd1,
        DEAD_HOLD = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_FWD   = 3'd1,
        DIR_BACK  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    localparam int DEF_CELL_SIZE = 32;
    localparam int DEF_H_CELLS   = 20;
    localparam int DEF_V_CELLS   = 15;

    // Frog start cell for the default grid: bottom row, middle column
    localparam int START_COL = DEF_H_CELLS / 2;
    localparam int START_ROW = DEF_V_CELLS - 1;

    // Cell index to 10-bit pixel coordinate
    function automatic logic [9:0] cell_to_pix(input logic [4:0] idx, input int cell_size);
        return 10'(int'(idx) * cell_size);
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// switch_debounce: 2-FF synchronizer, debounce counter and press strobe for one raw switch.
// The debounced level flips only after DEBOUNCE_CYCLES consecutive synchronized
// samples that differ from it; press pulses for one cycle when it flips to 1.
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic          press_reg;
    logic [CW-1:0] count_reg;

    // Bring the asynchronous switch into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
        end
    end

    // Count consecutive differing samples; flip the level and strobe on a rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_reg <= 1'b0;
            press_reg <= 1'b0;
            count_reg <= '0;
        end else begin
            press_reg <= 1'b0;
            if (sync2_reg != level_reg) begin
                if (count_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level_reg <= sync2_reg;
                    press_reg <= sync2_reg;
                    count_reg <= '0;
                end else begin
                    count_reg <= count_reg + 1'b1;
                end
            end else begin
                count_reg <= '0;
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/frog_control.sv
// frog_control: turns four debounced switches into grid moves and tracks frog
// position, level and lives for the renderer.
// Optional feature macro: FROG_LIVES_EN (lives counter and GAME_OVER state).
// Without it o_Lives is fixed at START_LIVES and a death always returns to PLAY.
module frog_control
    import frog_pkg::*;
#(
    parameter int H_CELLS         = DEF_H_CELLS,
    parameter int V_CELLS         = DEF_V_CELLS,
    parameter int CELL_SIZE       = DEF_CELL_SIZE,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_CYCLES     = 12500000,
    parameter int MAX_LEVEL       = 9,
    parameter int START_LIVES     = 3
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Switch_1,
    input  logic       i_Switch_2,
    input  logic       i_Switch_3,
    input  logic       i_Switch_4,
    input  logic       i_Hit,
    output logic [9:0] o_Frog_X,
    output logic [9:0] o_Frog_Y,
    output logic [3:0] o_Level,
    output logic [1:0] o_Lives,
    output logic       o_Game_Over,
    output logic       o_Move_Pulse
);

    localparam int          HW      = $clog2(HOLD_CYCLES + 1);
    localparam logic [4:0]  START_C = 5'(H_CELLS / 2);
    localparam logic [3:0]  START_R = 4'(V_CELLS - 1);
    localparam logic [9:0]  START_X = cell_to_pix(START_C, CELL_SIZE);
    localparam logic [9:0]  START_Y = cell_to_pix({1'b0, START_R}, CELL_SIZE);

    // Bit order: 0 = left, 1 = backward, 2 = forward, 3 = right
    logic [3:0] raw_sw;
    logic [3:0] press_sw;

    assign raw_sw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sw
            switch_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk  (i_Clk),
                .rst_n(i_Rst_L),
                .raw  (raw_sw[gi]),
                .press(press_sw[gi])
            );
        end
    endgenerate

    state_t          state_reg;
    logic [4:0]      col_reg;
    logic [3:0]      row_reg;
    logic [9:0]      x_reg;
    logic [9:0]      y_reg;
    logic [3:0]      level_reg;
    logic [HW-1:0]   hold_cnt_reg;
    logic            move_pulse_reg;
`ifdef FROG_LIVES_EN
    logic [1:0]      lives_reg;
    logic            game_over_reg;
`endif

    dir_t       dir;
    logic [4:0] col_next;
    logic [3:0] row_next;
    logic       move_ok;
    logic       move_win;
    logic       hold_done;

    assign hold_done = (hold_cnt_reg == HW'(HOLD_CYCLES - 1));

    // Pick one press by priority and work out the clamped target cell
    always_comb begin
        dir      = DIR_NONE;
        col_next = col_reg;
        row_next = row_reg;
        move_ok  = 1'b0;
        if (press_sw[2])      dir = DIR_FWD;
        else if (press_sw[1]) dir = DIR_BACK;
        else if (press_sw[0]) dir = DIR_LEFT;
        else if (press_sw[3]) dir = DIR_RIGHT;
        case (dir)
            DIR_FWD:   if (row_reg != 4'd0)              begin row_next = row_reg - 4'd1; move_ok = 1'b1; end
            DIR_BACK:  if (row_reg != 4'(V_CELLS - 1))   begin row_next = row_reg + 4'd1; move_ok = 1'b1; end
            DIR_LEFT:  if (col_reg != 5'd0)              begin col_next = col_reg - 5'd1; move_ok = 1'b1; end
            DIR_RIGHT: if (col_reg != 5'(H_CELLS - 1))   begin col_next = col_reg + 5'd1; move_ok = 1'b1; end
            default: ;
        endcase
        move_win = move_ok && (dir == DIR_FWD) && (row_next == 4'd0);
    end

    // Game state machine with registered position, level and lives
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_reg      <= PLAY;
            col_reg        <= START_C;
            row_reg        <= START_R;
            x_reg          <= START_X;
            y_reg          <= START_Y;
            level_reg      <= 4'd1;
            hold_cnt_reg   <= '0;
            move_pulse_reg <= 1'b0;
`ifdef FROG_LIVES_EN
            lives_reg      <= 2'(START_LIVES);
            game_over_reg  <= 1'b0;
`endif
        end else begin
            move_pulse_reg <= 1'b0;
            case (state_reg)
                PLAY: begin
                    if (i_Hit) begin
                        // A hit overrides any move in the same cycle
                        state_reg    <= DEAD_HOLD;
                        hold_cnt_reg <= '0;
`ifdef FROG_LIVES_EN
                        lives_reg    <= lives_reg - 2'd1;
`endif
                    end else if (move_ok) begin
                        col_reg        <= col_next;
                        row_reg        <= row_next;
                        x_reg          <= cell_to_pix(col_next, CELL_SIZE);
                        y_reg          <= cell_to_pix({1'b0, row_next}, CELL_SIZE);
                        move_pulse_reg <= 1'b1;
                        if (move_win) begin
                            state_reg    <= WIN_HOLD;
                            hold_cnt_reg <= '0;
                            level_reg    <= (level_reg >= 4'(MAX_LEVEL)) ? 4'(MAX_LEVEL)
                                                                         : level_reg + 4'd1;
                        end
                    end
                end
                WIN_HOLD, DEAD_HOLD: begin
                    if (hold_done) begin
                        hold_cnt_reg <= '0;
                        col_reg      <= START_C;
                        row_reg      <= START_R;
                        x_reg        <= START_X;
                        y_reg        <= START_Y;
                        state_reg    <= PLAY;
`ifdef FROG_LIVES_EN
                        if (state_reg == DEAD_HOLD && lives_reg == 2'd0) begin
                            state_reg     <= GAME_OVER;
                            game_over_reg <= 1'b1;
                        end
`endif
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                end
`ifdef FROG_LIVES_EN
                GAME_OVER: begin
                    if (|press_sw) begin
                        state_reg     <= PLAY;
                        lives_reg     <= 2'(START_LIVES);
                        level_reg     <= 4'd1;
                        col_reg       <= START_C;
                        row_reg       <= START_R;
                        x_reg         <= START_X;
                        y_reg         <= START_Y;
                        game_over_reg <= 1'b0;
                    end
                end
`endif
                default: state_reg <= PLAY;
            endcase
        end
    end

    assign o_Frog_X     = x_reg;
    assign o_Frog_Y     = y_reg;
    assign o_Level      = level_reg;
    assign o_Move_Pulse = move_pulse_reg;
`ifdef FROG_LIVES_EN
    assign o_Lives      = lives_reg;
    assign o_Game_Over  = game_over_reg;
`else
    assign o_Lives      = 2'(START_LIVES);
    assign o_Game_Over  = 1'b0;
`endif

endmodule

// File: doc/frog_control.md
# frog_control

Player-control stage that sits directly upstream of the Frogger top-level renderer. It turns the four raw board switches into debounced, single-step grid moves. It also tracks the frog position, level and lives, and reacts to the collision flag fed back from the renderer. Its outputs drive the renderer's frog sprite and the seven-segment level display.

## Interface
Parameters:
- H_CELLS, 20: grid columns (640 / 32)
- V_CELLS, 15: grid rows (480 / 32)
- CELL_SIZE, 32: pixels per cell; position outputs are cell index × CELL_SIZE
- DEBOUNCE_CYCLES, 250000: consecutive stable samples required to accept a switch change
- HOLD_CYCLES, 12500000: pause length after a win or a death
- MAX_LEVEL, 9: level saturation value
- START_LIVES, 3: lives at reset and at restart

Ports:
- i_Clk, in, 1: system clock (25 MHz pixel clock); single clock domain
- i_Rst_L, in, 1: reset, asynchronous assert, active-low
- i_Switch_1..4, in, 1 each: raw switches, left / backward / forward / right; asynchronous
- i_Hit, in, 1: level-sensitive collision flag from the renderer
- o_Frog_X, out, 10: frog pixel x
- o_Frog_Y, out, 10: frog pixel y
- o_Level, out, 4: current level, 1..MAX_LEVEL
- o_Lives, out, 2: remaining lives
- o_Game_Over, out, 1: high in GAME_OVER
- o_Move_Pulse, out, 1: one-cycle strobe on every accepted move

## Operation
- Each switch passes through a 2-FF synchronizer, then a debounce counter. The debounced level toggles only after DEBOUNCE_CYCLES consecutive samples that differ from the current level.
- A rising edge of a debounced level is a press. Releases are ignored.
- Start cell: column H_CELLS/2, row V_CELLS−1. With default parameters this gives x=320, y=448.
- State machine states: PLAY, WIN_HOLD, DEAD_HOLD, GAME_OVER.
- PLAY:
  - A press moves the frog one cell: forward = row−1, backward = row+1, left = col−1, right = col+1.
  - Moves clamp at grid edges. A clamped press does not move the frog and does not pulse o_Move_Pulse.
  - If several presses arrive in the same cycle, only one is taken, with priority forward > backward > left > right.
  - A forward move into row 0 goes to WIN_HOLD and increments the level, saturating at MAX_LEVEL.
  - i_Hit high goes to DEAD_HOLD and decrements lives.
  - If i_Hit and a winning move occur in the same cycle, the hit wins: no move, no level change.
- WIN_HOLD and DEAD_HOLD:
  - Run for HOLD_CYCLES cycles. Presses and i_Hit are discarded.
  - The frog stays visible at its current cell.
  - On exit, the frog returns to the start cell and the state goes to PLAY. From DEAD_HOLD with lives = 0, the state goes to GAME_OVER instead.
- GAME_OVER:
  - Outputs are frozen and o_Game_Over = 1.
  - The next press of any switch restarts: lives = START_LIVES, level = 1, frog at start, state PLAY.
- Arithmetic: cell indices are 5 bits for columns and 4 bits for rows. Pixel outputs are index × CELL_SIZE, registered, and 10 bits wide.

## Timing
- Reset values: o_Frog_X = 320, o_Frog_Y = 448, o_Level = 1, o_Lives = START_LIVES, o_Game_Over = 0, o_Move_Pulse = 0. State = PLAY; debounced levels = 0; counters = 0.
- Press latency: a raw edge held stable reaches the debounced output after 2 + DEBOUNCE_CYCLES cycles.
- On the cycle after the debounced rise, o_Frog_X/Y update and o_Move_Pulse is high for exactly one cycle.
- i_Hit is sampled every PLAY cycle. DEAD_HOLD and the lives decrement are visible the next cycle.
- Hold counter: HOLD_CYCLES cycles from entry to the exit transition inclusive.
- Reset asserted mid-hold or mid-debounce clears everything immediately. There is no residual press after reset release, even if a switch is held: the debounced level starts at 0 and its rise counts as a press only after a full debounce.

## Configuration
- FROG_LIVES_EN defined: lives counter, DEAD_HOLD → GAME_OVER path and GAME_OVER state are present, as described above.
- FROG_LIVES_EN undefined:
  - o_Lives is tied to START_LIVES and o_Game_Over is tied to 0.
  - A hit still enters DEAD_HOLD, then always returns to PLAY at the start cell.
  - The GAME_OVER state is not synthesized.

## Structure
- Package frog_pkg holds:
  - state enum typedef (PLAY, WIN_HOLD, DEAD_HOLD, GAME_OVER)
  - direction enum
  - default CELL_SIZE, H_CELLS, V_CELLS
  - start column/row constants
- Sub-module switch_debounce: synchronizer + debounce counter + rising-edge strobe, parameterized by DEBOUNCE_CYCLES, instantiated four times.

## Test plan
Run with DEBOUNCE_CYCLES = 4 and HOLD_CYCLES = 8.
- Reset, then press forward once → after 2+4+1 cycles o_Frog_Y = 416, o_Frog_X = 320, one o_Move_Pulse.
- Switch 4 bouncing 1-0-1 at 2-cycle intervals, then stable high → exactly one move, o_Frog_X = 352.
- Press left 11 times from start → o_Frog_X saturates at 0; the 11th press gives no pulse.
- 14 forward presses → o_Frog_Y = 0, WIN_HOLD, o_Level = 2. After 8 cycles the frog is back at 320/448. Repeat to level 9, then one more win → level stays 9.
- Assert i_Hit 3 times in PLAY → o_Lives goes 2, 1, 0, then o_Game_Over = 1. Press switch 2 → lives 3, level 1, frog at start.
- i_Hit high in the same cycle as the winning forward press → DEAD_HOLD, level unchanged, o_Frog_Y = 32.
